// File: rtl/cache_axi_arbiter.sv
// Arbitrates the single cache-line AXI bridge port between the icache and the dcache.
// Write-back beats refill; ties between the two refills are broken round-robin.
module cache_axi_arbiter (
    input  logic         clk,
    input  logic         resetn,

    input  logic         icache_rd_req,
    input  logic [31:0]  icache_rd_addr,
    output logic         icache_rd_rdy,
    output logic         icache_ret_valid,
    output logic [127:0] icache_ret_data,

    input  logic         dcache_rd_req,
    input  logic [31:0]  dcache_rd_addr,
    output logic         dcache_rd_rdy,
    output logic         dcache_ret_valid,
    output logic [127:0] dcache_ret_data,

    input  logic         dcache_wr_req,
    input  logic [31:0]  dcache_wr_addr,
    input  logic [127:0] dcache_wr_data,
    output logic         dcache_wr_rdy,
    output logic         dcache_wr_valid,

    output logic         axi_rd_req,
    output logic [31:0]  axi_rd_addr,
    input  logic         axi_rd_rdy,
    input  logic         axi_ret_valid,
    input  logic [127:0] axi_ret_data,

    output logic         axi_wr_req,
    output logic [31:0]  axi_wr_addr,
    output logic [127:0] axi_wr_data,
    input  logic         axi_wr_rdy,
    input  logic         axi_wr_valid
);

    typedef enum logic [1:0] {StIdle, StIRd, StDRd, StDWr} state_e;

    state_e state_q;
    logic   last_grant_q;  // 0: icache read granted last, 1: dcache read granted last

    logic in_idle;
    logic win_wr;
    logic win_ird;
    logic win_drd;

    always_comb begin
        in_idle = (state_q == StIdle);
        win_wr  = in_idle & dcache_wr_req;
        win_ird = in_idle & ~dcache_wr_req & icache_rd_req & (~dcache_rd_req | last_grant_q);
        win_drd = in_idle & ~dcache_wr_req & dcache_rd_req & (~icache_rd_req | ~last_grant_q);
    end

    always_comb begin
        axi_rd_req       = win_ird | win_drd;
        axi_rd_addr      = '0;
        if (win_ird) axi_rd_addr = icache_rd_addr;
        if (win_drd) axi_rd_addr = dcache_rd_addr;

        axi_wr_req       = win_wr;
        axi_wr_addr      = win_wr ? dcache_wr_addr : '0;
        axi_wr_data      = win_wr ? dcache_wr_data : '0;

        icache_rd_rdy    = win_ird & axi_rd_rdy;
        dcache_rd_rdy    = win_drd & axi_rd_rdy;
        dcache_wr_rdy    = win_wr & axi_wr_rdy;

        // Responses only reach the owner; one seen while idle is dropped.
        icache_ret_valid = (state_q == StIRd) & axi_ret_valid;
        dcache_ret_valid = (state_q == StDRd) & axi_ret_valid;
        dcache_wr_valid  = (state_q == StDWr) & axi_wr_valid;

        icache_ret_data  = '0;
        dcache_ret_data  = '0;
        if (state_q == StIRd || state_q == StDRd) begin
            icache_ret_data = axi_ret_data;
            dcache_ret_data = axi_ret_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_wr && axi_wr_rdy) begin
                        state_q <= StDWr;
                    end else if (win_ird && axi_rd_rdy) begin
                        state_q      <= StIRd;
                        last_grant_q <= 1'b0;
                    end else if (win_drd && axi_rd_rdy) begin
                        state_q      <= StDRd;
                        last_grant_q <= 1'b1;
                    end
                end
                StIRd, StDRd: begin
                    if (axi_ret_valid) state_q <= StIdle;
                end
                StDWr: begin
                    if (axi_wr_valid) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed self-checking bench for cache_axi_arbiter: refill routing, write priority,
// round-robin ties, busy blocking, stray responses and asynchronous reset.
module tb_cache_axi_arbiter;

    logic         clk;
    logic         resetn;
    logic         icache_rd_req;
    logic [31:0]  icache_rd_addr;
    logic         icache_rd_rdy;
    logic         icache_ret_valid;
    logic [127:0] icache_ret_data;
    logic         dcache_rd_req;
    logic [31:0]  dcache_rd_addr;
    logic         dcache_rd_rdy;
    logic         dcache_ret_valid;
    logic [127:0] dcache_ret_data;
    logic         dcache_wr_req;
    logic [31:0]  dcache_wr_addr;
    logic [127:0] dcache_wr_data;
    logic         dcache_wr_rdy;
    logic         dcache_wr_valid;
    logic         axi_rd_req;
    logic [31:0]  axi_rd_addr;
    logic         axi_rd_rdy;
    logic         axi_ret_valid;
    logic [127:0] axi_ret_data;
    logic         axi_wr_req;
    logic [31:0]  axi_wr_addr;
    logic [127:0] axi_wr_data;
    logic         axi_wr_rdy;
    logic         axi_wr_valid;

    int checks;
    int failures;

    cache_axi_arbiter dut (
        .clk              (clk),
        .resetn           (resetn),
        .icache_rd_req    (icache_rd_req),
        .icache_rd_addr   (icache_rd_addr),
        .icache_rd_rdy    (icache_rd_rdy),
        .icache_ret_valid (icache_ret_valid),
        .icache_ret_data  (icache_ret_data),
        .dcache_rd_req    (dcache_rd_req),
        .dcache_rd_addr   (dcache_rd_addr),
        .dcache_rd_rdy    (dcache_rd_rdy),
        .dcache_ret_valid (dcache_ret_valid),
        .dcache_ret_data  (dcache_ret_data),
        .dcache_wr_req    (dcache_wr_req),
        .dcache_wr_addr   (dcache_wr_addr),
        .dcache_wr_data   (dcache_wr_data),
        .dcache_wr_rdy    (dcache_wr_rdy),
        .dcache_wr_valid  (dcache_wr_valid),
        .axi_rd_req       (axi_rd_req),
        .axi_rd_addr      (axi_rd_addr),
        .axi_rd_rdy       (axi_rd_rdy),
        .axi_ret_valid    (axi_ret_valid),
        .axi_ret_data     (axi_ret_data),
        .axi_wr_req       (axi_wr_req),
        .axi_wr_addr      (axi_wr_addr),
        .axi_wr_data      (axi_wr_data),
        .axi_wr_rdy       (axi_wr_rdy),
        .axi_wr_valid     (axi_wr_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every output folded into one vector; all-zero means a fully quiet interface.
    logic [12:0] all_outs;
    assign all_outs = {icache_rd_rdy, icache_ret_valid, dcache_rd_rdy, dcache_ret_valid,
                       dcache_wr_rdy, dcache_wr_valid, axi_rd_req, axi_wr_req,
                       |axi_rd_addr, |axi_wr_addr, |axi_wr_data,
                       |icache_ret_data, |dcache_ret_data};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] LineA = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] LineB = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
    localparam logic [127:0] LineW = 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF;

    initial begin
        checks = 0;
        failures = 0;
        resetn = 1'b0;
        icache_rd_req = 1'b0; icache_rd_addr = '0;
        dcache_rd_req = 1'b0; dcache_rd_addr = '0;
        dcache_wr_req = 1'b0; dcache_wr_addr = '0; dcache_wr_data = '0;
        axi_rd_rdy = 1'b0; axi_ret_valid = 1'b0; axi_ret_data = '0;
        axi_wr_rdy = 1'b0; axi_wr_valid = 1'b0;
        #2;
        chk("reset_outputs_zero", all_outs, 13'h0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("idle_outputs_zero", all_outs, 13'h0);

        // Single icache refill
        icache_rd_req = 1'b1; icache_rd_addr = 32'h1FC0_0100; axi_rd_rdy = 1'b1;
        #1;
        chk("i1_axi_rd_req", axi_rd_req, 1);
        chk("i1_axi_rd_addr", axi_rd_addr, 32'h1FC0_0100);
        chk("i1_icache_rdy", icache_rd_rdy, 1);
        chk("i1_dcache_rdy", dcache_rd_rdy, 0);
        tick();
        icache_rd_req = 1'b0;
        #1;
        chk("i1_busy_no_axi_req", axi_rd_req, 0);
        tick();
        tick();
        axi_ret_valid = 1'b1; axi_ret_data = LineA;
        #1;
        chk("i1_ret_valid", icache_ret_valid, 1);
        chk("i1_ret_data", icache_ret_data, LineA);
        chk("i1_d_ret_valid", dcache_ret_valid, 0);
        tick();
        axi_ret_valid = 1'b0;

        // Tie straight after reset goes to icache
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        icache_rd_req = 1'b1; icache_rd_addr = 32'h0000_1000;
        dcache_rd_req = 1'b1; dcache_rd_addr = 32'h8000_2000;
        #1;
        chk("tie1_icache_rdy", icache_rd_rdy, 1);
        chk("tie1_dcache_rdy", dcache_rd_rdy, 0);
        chk("tie1_addr", axi_rd_addr, 32'h0000_1000);
        tick();
        icache_rd_req = 1'b0;
        #1;
        chk("tie1_busy_d_rdy", dcache_rd_rdy, 0);
        axi_ret_valid = 1'b1; axi_ret_data = LineA;
        #1;
        chk("tie1_ret_i", icache_ret_valid, 1);
        chk("tie1_ret_same_cycle_no_accept", dcache_rd_rdy, 0);
        tick();
        axi_ret_valid = 1'b0; icache_rd_req = 1'b1;
        #1;
        chk("tie2_dcache_rdy", dcache_rd_rdy, 1);
        chk("tie2_icache_rdy", icache_rd_rdy, 0);
        chk("tie2_addr", axi_rd_addr, 32'h8000_2000);
        tick();
        dcache_rd_req = 1'b0;
        #1;
        // Busy blocking: icache held high with bridge ready during D_RD
        chk("busy_icache_rdy_a", icache_rd_rdy, 0);
        chk("busy_axi_rd_req", axi_rd_req, 0);
        tick();
        chk("busy_icache_rdy_b", icache_rd_rdy, 0);
        axi_ret_valid = 1'b1; axi_ret_data = LineB;
        #1;
        chk("d_ret_valid", dcache_ret_valid, 1);
        chk("d_ret_data", dcache_ret_data, LineB);
        chk("d_ret_i_valid", icache_ret_valid, 0);
        tick();
        axi_ret_valid = 1'b0;
        #1;
        chk("idle_icache_rdy", icache_rd_rdy, 1);
        icache_rd_req = 1'b0;
        #1;

        // Stray responses while idle are ignored
        axi_ret_valid = 1'b1; axi_wr_valid = 1'b1;
        #1;
        chk("stray_valids", {icache_ret_valid, dcache_ret_valid, dcache_wr_valid}, 3'b000);
        tick();
        axi_ret_valid = 1'b0; axi_wr_valid = 1'b0;

        // Request dropped before acceptance leaves the arbiter idle
        axi_rd_rdy = 1'b0; icache_rd_req = 1'b1;
        #1;
        chk("drop_req_fwd", {axi_rd_req, icache_rd_rdy}, 2'b10);
        tick();
        icache_rd_req = 1'b0; dcache_rd_req = 1'b1; axi_rd_rdy = 1'b1;
        #1;
        chk("drop_then_d_rdy", dcache_rd_rdy, 1);
        dcache_rd_req = 1'b0;
        #1;

        // Write priority over both reads (last read grant was dcache)
        icache_rd_req = 1'b1; dcache_rd_req = 1'b1; dcache_wr_req = 1'b1;
        dcache_wr_addr = 32'h8000_3040; dcache_wr_data = LineW; axi_wr_rdy = 1'b1;
        #1;
        chk("wp_axi_wr_req", axi_wr_req, 1);
        chk("wp_axi_wr_addr", axi_wr_addr, 32'h8000_3040);
        chk("wp_axi_wr_data", axi_wr_data, LineW);
        chk("wp_rd_side", {axi_rd_req, icache_rd_rdy, dcache_rd_rdy, dcache_wr_rdy}, 4'b0001);
        tick();
        dcache_wr_req = 1'b0;
        #1;
        chk("wp_busy_quiet", {axi_wr_req, axi_rd_req, icache_rd_rdy, dcache_rd_rdy}, 4'b0);
        axi_wr_valid = 1'b1;
        #1;
        chk("wp_wr_valid", dcache_wr_valid, 1);
        tick();
        axi_wr_valid = 1'b0;
        #1;
        chk("wp_then_icache", {icache_rd_rdy, dcache_rd_rdy}, 2'b10);
        tick();
        icache_rd_req = 1'b0;
        axi_ret_valid = 1'b1;
        tick();
        axi_ret_valid = 1'b0;
        #1;
        chk("wp_then_dcache", {icache_rd_rdy, dcache_rd_rdy}, 2'b01);
        tick();
        dcache_rd_req = 1'b0;
        axi_ret_valid = 1'b1;
        tick();
        axi_ret_valid = 1'b0;

        // Reset during D_WR; an icache read first so a tie would otherwise favour dcache
        icache_rd_req = 1'b1;
        tick();
        icache_rd_req = 1'b0;
        axi_ret_valid = 1'b1;
        tick();
        axi_ret_valid = 1'b0;
        dcache_wr_req = 1'b1;
        tick();
        dcache_wr_req = 1'b0;
        axi_wr_valid = 1'b1;
        #1;
        chk("rst_pre_wr_valid", dcache_wr_valid, 1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_outputs_zero", all_outs, 13'h0);
        axi_wr_valid = 1'b0;
        tick();
        resetn = 1'b1;
        icache_rd_req = 1'b1; dcache_rd_req = 1'b1;
        #1;
        chk("rst_tie_icache", {icache_rd_rdy, dcache_rd_rdy}, 2'b10);
        chk("rst_tie_addr", axi_rd_addr, 32'h0000_1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
